// File: rtl/div_unit_pkg.sv
// Shared constants for the execute-stage divider: state encodings, handshake
// levels and the DIV/DIVU aluop codes used by the initiator.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_unit_step.sv
// One radix-2 restoring step: shift in the next dividend bit, trial-subtract
// the divisor magnitude, keep the difference when it does not go negative.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_o
);

    localparam int unsigned RW = WIDTH + 2;

    logic [RW-1:0] diff;

    // The extra top bit doubles as the borrow/sign of the trial subtraction.
    always_comb begin
        diff  = {rem_i, bit_i} - RW'({1'b0, divisor_i});
        q_o   = ~diff[RW-1];
        rem_o = diff[RW-1] ? {rem_i[WIDTH-1:0], bit_i} : diff[WIDTH:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the HI/LO path: 32 restoring steps
// on operand magnitudes followed by a sign fixup; result = {rem, quot}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WIDTH:0]       rem_q, rem_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 signed_q, signed_d;
    logic                 dvd_neg_q, dvd_neg_d;
    logic                 dvs_neg_q, dvs_neg_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;

    logic [WIDTH:0]       step_rem;
    logic                 step_q;
    logic                 neg1, neg2;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dvd_q[WIDTH-1]),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    // The dividend register shifts out dividend bits and shifts in quotient bits.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        signed_d  = signed_q;
        dvd_neg_d = dvd_neg_q;
        dvs_neg_d = dvs_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;

        neg1    = signed_div_i & opdata1_i[WIDTH-1];
        neg2    = signed_div_i & opdata2_i[WIDTH-1];
        quo_fix = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? (~dvd_q + WIDTH'(1)) : dvd_q;
        rem_fix = (signed_q & dvd_neg_q) ? (~rem_q[WIDTH-1:0] + WIDTH'(1))
                                         : rem_q[WIDTH-1:0];

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                cnt_d    = '0;
                if (start_i == DIV_START && !annul_i) begin
                    signed_d  = signed_div_i;
                    dvd_neg_d = neg1;
                    dvs_neg_d = neg2;
                    dvd_d     = neg1 ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
                    dvs_d     = neg2 ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
                    rem_d     = '0;
                    state_d   = (opdata2_i == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                end else begin
                    state_d  = DIV_END;
                    result_d = '0;
                    ready_d  = DIV_RESULT_READY;
                end
            end
            DIV_ON: begin
                if (annul_i) begin
                    state_d = DIV_FREE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    state_d  = DIV_END;
                    cnt_d    = '0;
                    result_d = {rem_fix, quo_fix};
                    ready_d  = DIV_RESULT_READY;
                end else begin
                    rem_d = step_rem;
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                end
            end
            default: state_d = DIV_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            signed_q  <= signed_d;
            dvd_neg_q <= dvd_neg_d;
            dvs_neg_q <= dvs_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
